// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and transmitter-side handshake bundle for uart_tx_arbiter.
// The arbiter uses the slave modport; requesters and the serializer model use master.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int OWNER_W = 2
);
  logic [NUM_REQ-1:0]   i_Req;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;
  logic [NUM_REQ-1:0]   o_Grant;
  logic [NUM_REQ-1:0]   o_Done;
  logic                 o_Busy;
  logic [OWNER_W-1:0]   o_Owner;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 o_Timeout;

  modport master (
    output i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    input  o_Grant, o_Done, o_Busy, o_Owner, o_Tx_DV, o_Tx_Byte, o_Timeout
  );

  modport slave (
    input  i_Req, i_Req_Byte, i_Tx_Active, i_Tx_Done,
    output o_Grant, o_Done, o_Busy, o_Owner, o_Tx_DV, o_Tx_Byte, o_Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters.
// Define UART_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that aborts after TIMEOUT_CLKS.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int OWNER_W      = 2,
  parameter int GAP_CLKS     = 16,
  parameter int TIMEOUT_CLKS = 10416
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  uart_tx_arbiter_if.slave     bus
);

  localparam int GAP_W = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_e;

  state_e               state_q, state_d;
  logic [OWNER_W-1:0]   ptr_q, ptr_d;
  logic [OWNER_W-1:0]   owner_q, owner_d;
  logic [7:0]           txByte_q, txByte_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 txDv_q, txDv_d;
  logic [GAP_W-1:0]     gapCnt_q, gapCnt_d;

  logic                 selFound;
  logic [OWNER_W-1:0]   selIdx;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  logic [TO_W-1:0]      toCnt_q, toCnt_d;
  logic                 timeout_q, timeout_d;
`endif

  function automatic logic [OWNER_W-1:0] rrIndex(input logic [OWNER_W-1:0] base,
                                                 input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_REQ) s -= NUM_REQ;
    return OWNER_W'(s);
  endfunction

  // Scan upward from the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    selFound = 1'b0;
    selIdx   = ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!selFound && bus.i_Req[rrIndex(ptr_q, i)]) begin
        selFound = 1'b1;
        selIdx   = rrIndex(ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    txByte_d = txByte_q;
    grant_d  = '0;
    done_d   = '0;
    txDv_d   = 1'b0;
    gapCnt_d = gapCnt_q;
`ifdef UART_ARB_TIMEOUT_EN
    toCnt_d   = toCnt_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!bus.i_Tx_Active && selFound) begin
          grant_d  = NUM_REQ'(1) << selIdx;
          owner_d  = selIdx;
          txByte_d = bus.i_Req_Byte[8*selIdx +: 8];
          ptr_d    = rrIndex(selIdx, 1);
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        txDv_d  = 1'b1;
        state_d = WAIT_DONE;
`ifdef UART_ARB_TIMEOUT_EN
        toCnt_d = '0;
`endif
      end
      WAIT_DONE: begin
        // A done pulse alongside the launch strobe cannot belong to this byte.
        if (bus.i_Tx_Done && !txDv_q) begin
          done_d   = NUM_REQ'(1) << owner_q;
          gapCnt_d = '0;
          state_d  = (GAP_CLKS == 0) ? IDLE : GAP;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (toCnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
          timeout_d = 1'b1;
          gapCnt_d  = '0;
          state_d   = (GAP_CLKS == 0) ? IDLE : GAP;
        end else begin
          toCnt_d = toCnt_q + 1'b1;
        end
`endif
      end
      GAP: begin
        if (gapCnt_q == GAP_W'(GAP_CLKS - 1)) begin
          gapCnt_d = '0;
          state_d  = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      txByte_q <= 8'h00;
      grant_q  <= '0;
      done_q   <= '0;
      txDv_q   <= 1'b0;
      gapCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      txByte_q <= txByte_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      txDv_q   <= txDv_d;
      gapCnt_q <= gapCnt_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      toCnt_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      toCnt_q   <= toCnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.o_Timeout = timeout_q;
`else
  assign bus.o_Timeout = 1'b0;
`endif

  assign bus.o_Grant   = grant_q;
  assign bus.o_Done    = done_q;
  assign bus.o_Busy    = (state_q != IDLE);
  assign bus.o_Owner   = owner_q;
  assign bus.o_Tx_DV   = txDv_q;
  assign bus.o_Tx_Byte = txByte_q;

endmodule
